// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-addressed async-read/sync-write memory; sub-word stores use read-modify-write.
// Define LSU_ALIGN_CHECK_EN to report misaligned halfword/word accesses as errors instead of performing them.
module load_store_unit #(
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_dout
);

  // IDLE accept | RD load read | RMW_RD sub-word store read | WR memory write | RESP completion pulse
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_funct3;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_merged;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_misalign;
  logic [31:0]           w_shift;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [31:0]           w_merge;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_illegal  = req_write ? (req_funct3 > 3'b010)
                           : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    w_misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_illegal || w_misalign)       w_next = S_RESP;
          else if (!req_write)               w_next = S_RD;
          else if (req_funct3[1:0] == 2'b10) w_next = S_WR;
          else                               w_next = S_RMW_RD;
        end
      end
      S_RD:     w_next = S_RESP;
      S_RMW_RD: w_next = S_WR;
      S_WR:     w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Halfword lane follows addr[1] only; addr[0] is either rejected or ignored.
  always_comb begin
    w_shift = mem_dout >> {r_addr[1:0], 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_dout;
    endcase
  end

  always_comb begin
    w_merge = mem_dout;
    if (r_funct3[1:0] == 2'b00)
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else if (r_addr[1])
      w_merge[31:16] = r_wdata[15:0];
    else
      w_merge[15:0] = r_wdata[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merged <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
        r_err    <= w_illegal || w_misalign;
      end
      if (r_state == S_RD)     r_rdata  <= w_load;
      if (r_state == S_RMW_RD) r_merged <= w_merge;
    end
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE) && reset;
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
    mem_read   = (r_state == S_RD) || (r_state == S_RMW_RD);
    mem_write  = (r_state == S_WR);
    mem_addr   = '0;
    mem_din    = '0;
    if (mem_read || mem_write)
      mem_addr = {r_addr[MEM_ADDR_W-1:2], 2'b00};
    if (mem_write)
      mem_din = (r_funct3[1:0] == 2'b10) ? r_wdata : r_merged;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory; expectations are hand-computed.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
  );

  logic [31:0] mem [0:255];
  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_din;

  int          tests = 0;
  int          fails = 0;
  int          lat;
  logic        o_err;
  logic [31:0] o_data;
  logic        saw_rd;
  logic        saw_wr;
  logic        both;
  logic        rdy_at_resp;
  logic [31:0] wr_data;
  logic        saw_resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge of the response cycle (lat = 99 on timeout).
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; o_err = 1'bx; o_data = 'x; saw_rd = 0; saw_wr = 0; rdy_at_resp = 1'bx; wr_data = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_read) saw_rd = 1;
      if (mem_write) begin saw_wr = 1; wr_data = mem_din; end
      if (mem_read && mem_write) both = 1;
      if (resp_valid) begin
        lat = i; o_err = resp_err; o_data = resp_rdata; rdy_at_resp = req_ready;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    both = 0;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("idle_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    // SW then LW
    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_lat", lat, 2);
    chk("sw_err", {31'd0, o_err}, 32'd0);
    chk("sw_no_read", {31'd0, saw_rd}, 32'd0);
    chk("sw_din", wr_data, 32'hDEADBEEF);
    chk("sw_mem64", mem[64], 32'hDEADBEEF);
    chk("resp_not_ready", {31'd0, rdy_at_resp}, 32'd0);
    access(1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_lat", lat, 2);
    chk("lw_data", o_data, 32'hDEADBEEF);
    chk("lw_no_write", {31'd0, saw_wr}, 32'd0);

    // SB read-modify-write; upper wdata bits must be ignored
    access(1'b1, 3'b010, 32'h100, 32'h11223344);
    access(1'b1, 3'b000, 32'h102, 32'hFFFFFF7F);
    chk("sb_lat", lat, 3);
    chk("sb_read", {31'd0, saw_rd}, 32'd1);
    chk("sb_din", wr_data, 32'h117F3344);
    chk("sb_mem64", mem[64], 32'h117F3344);

    // Sub-word loads on 0x80FF0000
    access(1'b1, 3'b010, 32'h100, 32'h80FF0000);
    access(1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb_103", o_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0);
    chk("lbu_103", o_data, 32'h00000080);
    access(1'b0, 3'b101, 32'h102, 32'h0);
    chk("lhu_102", o_data, 32'h000080FF);
    access(1'b0, 3'b001, 32'h102, 32'h0);
    chk("lh_102", o_data, 32'hFFFF80FF);
    access(1'b0, 3'b000, 32'h102, 32'h0);
    chk("lb_102", o_data, 32'hFFFFFFFF);
    access(1'b0, 3'b001, 32'h100, 32'h0);
    chk("lh_100", o_data, 32'h00000000);

    // SH upper lane, then SB lane 0
    access(1'b1, 3'b010, 32'h108, 32'h11223344);
    access(1'b1, 3'b001, 32'h10A, 32'h0000BEEF);
    chk("sh_lat", lat, 3);
    chk("sh_mem66", mem[66], 32'hBEEF3344);
    access(1'b1, 3'b000, 32'h108, 32'h000000AA);
    chk("sb0_mem66", mem[66], 32'hBEEF33AA);

    // Misaligned accesses
    access(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis_lw_lat", lat, 1);
    chk("mis_lw_err", {31'd0, o_err}, 32'd1);
    chk("mis_lw_no_read", {31'd0, saw_rd}, 32'd0);
    chk("mis_lw_data", o_data, 32'd0);
    access(1'b0, 3'b001, 32'h103, 32'h0);
    chk("mis_lh_err", {31'd0, o_err}, 32'd1);
`else
    chk("mis_lw_lat", lat, 2);
    chk("mis_lw_err", {31'd0, o_err}, 32'd0);
    chk("mis_lw_data", o_data, 32'h80FF0000);
    access(1'b0, 3'b001, 32'h103, 32'h0);
    chk("mis_lh_data", o_data, 32'hFFFF80FF);
`endif

    // Illegal funct3
    access(1'b0, 3'b110, 32'h100, 32'h0);
    chk("ill_ld_lat", lat, 1);
    chk("ill_ld_err", {31'd0, o_err}, 32'd1);
    chk("ill_ld_data", o_data, 32'd0);
    chk("ill_ld_strobes", {30'd0, saw_rd, saw_wr}, 32'd0);
    access(1'b1, 3'b011, 32'h100, 32'h12345678);
    chk("ill_st_err", {31'd0, o_err}, 32'd1);
    chk("ill_st_no_write", {31'd0, saw_wr}, 32'd0);
    chk("ill_st_mem64", mem[64], 32'h80FF0000);
    access(1'b0, 3'b010, 32'h100, 32'h0);
    chk("after_err_ok", {31'd0, o_err}, 32'd0);

    // Reset during RMW_RD of SH @0x104
    access(1'b1, 3'b010, 32'h104, 32'hAABBCCDD);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h104; req_wdata = 32'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_read_before_rst", {31'd0, mem_read}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_read_drop", {31'd0, mem_read}, 32'd0);
    chk("rst_write_drop", {31'd0, mem_write}, 32'd0);
    saw_resp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1;
    end
    reset = 1'b1;
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || mem_write) saw_resp = 1;
    end
    chk("rst_no_resp", {31'd0, saw_resp}, 32'd0);
    chk("rst_mem65", mem[65], 32'hAABBCCDD);
    access(1'b0, 3'b010, 32'h104, 32'h0);
    chk("post_rst_lw", o_data, 32'hAABBCCDD);

    chk("never_rd_and_wr", {31'd0, both}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle RV32I load/store unit sitting between the core's execute stage and `data_memory`. It accepts one byte, halfword or word access per request and drives the word-addressed, asynchronous-read / synchronous-write memory port. Sub-word stores are done as read-modify-write, and loads return a sign- or zero-extended result through a single-cycle response pulse.

## Interface
- `MEM_ADDR_W`, 32, width of `req_addr` and `mem_addr`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `req_valid`  in  1  access request.
- `req_ready`  out  1  unit can accept a request; high only in IDLE while `reset`=1.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `req_addr`  in  MEM_ADDR_W  byte address.
- `req_wdata`  in  32  store data; bytes taken from the LSBs.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal funct3; qualified by `resp_valid`.
- `mem_addr`  out  MEM_ADDR_W  word-aligned address (`{addr[31:2],2'b00}`).
- `mem_din`  out  32  write data to memory.
- `mem_read`  out  1  read strobe.
- `mem_write`  out  1  write strobe; memory writes on the rising edge while high.
- `mem_dout`  in  32  asynchronous read data.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, latch `req_write`, `req_funct3`, `req_addr` and `req_wdata`, then select the next state:
  - error -> RESP;
  - load -> RD;
  - SW -> WR;
  - SB or SH -> RMW_RD.
- Errors:
  - Illegal funct3: load funct3 in {011, 110, 111}; store funct3 not in {000, 001, 010}.
  - Misaligned (only with the configuration macro defined): halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
- RD: `mem_read`=1. Select the byte or halfword from `mem_dout` using `addr[1:0]` (little-endian). Sign-extend for LB/LH, zero-extend for LBU/LHU. Register the result into `resp_rdata`, then go to RESP.
- RMW_RD: `mem_read`=1. Merge `req_wdata[7:0]` or `req_wdata[15:0]` into `mem_dout` at the byte lane given by `addr[1:0]` and register the merged word, then go to WR.
- WR: `mem_write`=1. `mem_din` = merged word for SB/SH, or `req_wdata` for SW. Then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
  - `req_ready`=0 in RESP, so back-to-back requests are spaced by one IDLE cycle.
- `mem_addr` is held constant from RD/RMW_RD through WR. It is 0 in IDLE and RESP.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Acceptance edge = cycle 0.
- Response (`resp_valid`) cycle:
  - load: 2;
  - SW: 2;
  - SB/SH: 3;
  - error: 1, with no memory strobe.
- Outputs are registered or decoded from state only; there is no combinational path from `req_*` to `mem_*`.
- Reset values (`reset`=0): state IDLE, `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_din`=0.
- Reset asserted mid-access:
  - all strobes drop immediately;
  - no response is issued;
  - an in-flight RMW that has not reached WR leaves memory unmodified.
- `req_valid` outside IDLE is ignored.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: misaligned accesses complete in RESP with `resp_err`=1 and no memory access.
- Not defined:
  - Misaligned halfword and word accesses are performed at the word address `addr[31:2]`.
  - The halfword lane is `addr[1]`; `addr[0]` is ignored.
  - Word accesses ignore `addr[1:0]`.
  - `resp_err` reports only illegal funct3.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 -> memory word 64 = 0xDEADBEEF; LW `resp_rdata`=0xDEADBEEF at cycle 2.
- SB 0x7F @0x102 onto word 0x11223344 -> WR at cycle 2 writes 0x117F3344; `resp_valid` at cycle 3.
- LB @0x103 on word 0x80FF0000 -> 0xFFFFFF80; LBU -> 0x00000080; LHU @0x102 -> 0x000080FF.
- With macro: LW @0x102 -> `resp_err`=1 at cycle 1, `mem_read` never high. Without macro: same access -> reads word 64, `resp_err`=0.
- Load funct3 110 -> `resp_err`=1, `resp_rdata`=0, no strobes.
- `reset` driven low during RMW_RD of SH @0x104 -> strobes 0 within the same cycle, word 65 unchanged, no `resp_valid`; after release, `req_ready`=1.
